// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and alignment helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StWr,
    StResp
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic is_misaligned(logic [2:0] funct3, logic [2:0] a);
    case (funct3)
      F3_H, F3_HU: return a[0];
      F3_W, F3_WU: return |a[1:0];
      F3_D:        return |a;
      default:     return 1'b0;
    endcase
  endfunction

  // Clears the address bits below the access size.
  function automatic logic [2:0] force_align(logic [2:0] funct3, logic [2:0] a);
    case (funct3[1:0])
      2'b01:   return {a[2:1], 1'b0};
      2'b10:   return {a[2], 2'b00};
      2'b11:   return 3'b000;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane merge for sub-dword stores.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] mem_rd,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wd
);

  logic [5:0]      sh;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;

  assign sh   = {off, 3'b000};
  assign lane = mem_rd >> sh;

  always_comb begin
    mask = '1;
    case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00ff;
      2'b01:   mask = 64'h0000_0000_0000_ffff;
      2'b10:   mask = 64'h0000_0000_ffff_ffff;
      default: mask = '1;
    endcase
  end

  always_comb begin
    rdata = lane;
    case (funct3)
      F3_B:    rdata = {{56{lane[7]}}, lane[7:0]};
      F3_H:    rdata = {{48{lane[15]}}, lane[15:0]};
      F3_W:    rdata = {{32{lane[31]}}, lane[31:0]};
      F3_BU:   rdata = {56'b0, lane[7:0]};
      F3_HU:   rdata = {48'b0, lane[15:0]};
      F3_WU:   rdata = {32'b0, lane[31:0]};
      default: rdata = lane;
    endcase
  end

  assign wd = (mem_rd & ~(mask << sh)) | ((wdata & mask) << sh);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: request latch, FSM and registered response/memory outputs.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing alignment.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_e      state;
  logic [2:0]      funct3_q;
  logic [2:0]      off_q;
  logic [XLEN-1:0] wdata_q;
  logic            mem_re_q;
  logic            mem_we_q;

  logic            acc_fault;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] merged;

  always_comb begin
    acc_fault = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    acc_fault = acc_fault || is_misaligned(req_funct3, req_addr[2:0]);
    acc_addr  = req_addr;
`else
    acc_addr  = {req_addr[XLEN-1:3], force_align(req_funct3, req_addr[2:0])};
`endif
  end

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .mem_rd(mem_rd),
    .wdata (wdata_q),
    .off   (off_q),
    .funct3(funct3_q),
    .rdata (ld_data),
    .wd    (merged)
  );

  assign req_ready = (state == StIdle);
  // Keep the enables low during a reset cycle so the memory never writes on that edge.
  assign mem_re    = mem_re_q & ~reset;
  assign mem_we    = mem_we_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      funct3_q   <= 3'b000;
      off_q      <= 3'b000;
      wdata_q    <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        StIdle: begin
          resp_rdata <= '0;
          resp_fault <= 1'b0;
          mem_a      <= '0;
          mem_wd     <= '0;
          if (req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= acc_addr[2:0];
            wdata_q  <= req_wdata;
            if (acc_fault) begin
              state      <= StResp;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else if (!req_we) begin
              state    <= StRd;
              mem_re_q <= 1'b1;
              mem_a    <= {acc_addr[XLEN-1:3], 3'b000};
            end else if (req_funct3[1:0] == 2'b11) begin
              state    <= StWr;
              mem_we_q <= 1'b1;
              mem_a    <= {acc_addr[XLEN-1:3], 3'b000};
              mem_wd   <= req_wdata;
            end else begin
              state    <= StRmwRd;
              mem_re_q <= 1'b1;
              mem_a    <= {acc_addr[XLEN-1:3], 3'b000};
            end
          end
        end
        StRd: begin
          state      <= StResp;
          resp_valid <= 1'b1;
          resp_rdata <= ld_data;
          mem_a      <= '0;
        end
        StRmwRd: begin
          state    <= StWr;
          mem_we_q <= 1'b1;
          mem_wd   <= merged;
        end
        StWr: begin
          state      <= StResp;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          mem_a      <= '0;
          mem_wd     <= '0;
        end
        StResp: begin
          state      <= StIdle;
          resp_rdata <= '0;
          resp_fault <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
